// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (7-bit address) in front of an 8-bit register file.
// SCL/SDA are oversampled on clk. Writes pulse wr_stb/wr_adr/wr_dat; reads stream mem[ptr].
module i2c_target_regs #(
    parameter logic [6:0]  I2C_ADR   = 7'h11,
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_stb,
    output logic [7:0] wr_adr,
    output logic [7:0] wr_dat
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // HOLD_CYC must be >= 1: the counter runs HOLD_CYC-1 .. 0 after the fall is registered
    localparam logic [7:0] HoldLoad = 8'(HOLD_CYC - 1);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StAddr     = 4'd1;
    localparam logic [3:0] StAddrAck  = 4'd2;
    localparam logic [3:0] StPtr      = 4'd3;
    localparam logic [3:0] StPtrAck   = 4'd4;
    localparam logic [3:0] StWdata    = 4'd5;
    localparam logic [3:0] StWdataAck = 4'd6;
    localparam logic [3:0] StRdata    = 4'd7;
    localparam logic [3:0] StRdataAck = 4'd8;
    localparam logic [3:0] StIgnore   = 4'd9;

    logic [2:0]    r_scl_pipe;  // [0],[1] synchronizer, [2] history
    logic [2:0]    r_sda_pipe;
    logic [3:0]    r_state;
    logic [2:0]    r_cnt;
    logic [6:0]    r_sr;
    logic [7:0]    r_tx;
    logic          r_rw;
    logic          r_ack_clk;   // ACK-bit SCL rise seen; leave the ACK state on the next fall
    logic [AW-1:0] r_ptr;
    logic          r_hold_act;
    logic [7:0]    r_hold_cnt;
    logic          r_sda_oe;
    logic          r_busy;
    logic          r_wr_stb;
    logic [7:0]    r_wr_adr;
    logic [7:0]    r_wr_dat;
    logic [7:0]    r_mem [MEM_DEPTH];

    logic          w_scl;
    logic          w_sda;
    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_start;
    logic          w_stop;
    logic [7:0]    w_sr_next;
    logic          w_ptr_ok;
    logic [AW-1:0] w_ptr_inc;
    logic          w_oe_target;

    assign w_scl      = r_scl_pipe[1];
    assign w_sda      = r_sda_pipe[1];
    assign w_scl_rise = w_scl & ~r_scl_pipe[2];
    assign w_scl_fall = ~w_scl & r_scl_pipe[2];
    assign w_start    = w_scl & ~w_sda & r_sda_pipe[2];
    assign w_stop     = w_scl & w_sda & ~r_sda_pipe[2];
    assign w_sr_next  = {r_sr, w_sda};
    assign w_ptr_ok   = ({1'b0, w_sr_next} < 9'(MEM_DEPTH));
    assign w_ptr_inc  = (r_ptr == AW'(MEM_DEPTH - 1)) ? '0 : r_ptr + AW'(1);

    // Pad synchronizers; reset to the idle-high bus level so release creates no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_pipe <= 3'b111;
            r_sda_pipe <= 3'b111;
        end else begin
            r_scl_pipe <= {r_scl_pipe[1:0], scl_i};
            r_sda_pipe <= {r_sda_pipe[1:0], sda_i};
        end
    end

    // Level SDA should take once the hold time after an SCL fall has elapsed
    always_comb begin
        w_oe_target = 1'b0;
        case (r_state)
            StAddrAck, StPtrAck, StWdataAck: w_oe_target = 1'b1;
            StRdata:                         w_oe_target = ~r_tx[7];
            default:                         w_oe_target = 1'b0;
        endcase
    end

    // Protocol FSM, pointer/shift datapath, register file and SDA hold timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_tx       <= '0;
            r_rw       <= 1'b0;
            r_ack_clk  <= 1'b0;
            r_ptr      <= '0;
            r_hold_act <= 1'b0;
            r_hold_cnt <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_stb   <= 1'b0;
            r_wr_adr   <= '0;
            r_wr_dat   <= '0;
            r_mem      <= '{default: '0};
        end else begin
            r_wr_stb <= 1'b0;
            if (w_stop) begin
                r_state    <= StIdle;
                r_busy     <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_hold_act <= 1'b0;
            end else if (w_start) begin
                r_state    <= StAddr;
                r_busy     <= 1'b1;
                r_cnt      <= '0;
                r_ack_clk  <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_hold_act <= 1'b0;
            end else begin
                if (r_hold_act) begin
                    if (r_hold_cnt == 8'd0) begin
                        r_sda_oe   <= w_oe_target;
                        r_hold_act <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                end
                if (w_scl_fall) begin
                    r_hold_act <= 1'b1;
                    r_hold_cnt <= HoldLoad;
                    if (r_ack_clk) begin
                        r_ack_clk <= 1'b0;
                        r_cnt     <= '0;
                        case (r_state)
                            StAddrAck: begin
                                if (r_rw) begin
                                    r_state <= StRdata;
                                    r_tx    <= r_mem[r_ptr];
                                end else begin
                                    r_state <= StPtr;
                                end
                            end
                            StPtrAck, StWdataAck: r_state <= StWdata;
                            default: ;
                        endcase
                    end
                end
                if (w_scl_rise) begin
                    case (r_state)
                        StAddr: begin
                            r_sr  <= w_sr_next[6:0];
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                if (w_sr_next[7:1] == I2C_ADR) begin
                                    r_rw    <= w_sr_next[0];
                                    r_state <= StAddrAck;
                                end else begin
                                    r_state <= StIgnore;
                                end
                            end
                        end
                        StPtr: begin
                            r_sr  <= w_sr_next[6:0];
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                if (w_ptr_ok) begin
                                    r_ptr   <= w_sr_next[AW-1:0];
                                    r_state <= StPtrAck;
                                end else begin
                                    r_state <= StIgnore;
                                end
                            end
                        end
                        StWdata: begin
                            r_sr  <= w_sr_next[6:0];
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_mem[r_ptr] <= w_sr_next;
                                r_wr_stb     <= 1'b1;
                                r_wr_adr     <= 8'(r_ptr);
                                r_wr_dat     <= w_sr_next;
                                r_ptr        <= w_ptr_inc;
                                r_state      <= StWdataAck;
                            end
                        end
                        StRdata: begin
                            // Shift now; the next bit reaches SDA only after the following fall
                            r_tx  <= {r_tx[6:0], 1'b0};
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_state <= StRdataAck;
                            end
                        end
                        StRdataAck: begin
                            r_ptr <= w_ptr_inc;
                            r_cnt <= '0;
                            if (!w_sda) begin
                                r_state <= StRdata;
                                r_tx    <= r_mem[w_ptr_inc];
                            end else begin
                                r_state <= StIgnore;
                            end
                        end
                        StAddrAck, StPtrAck, StWdataAck: r_ack_clk <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sda_oe = r_sda_oe;
    assign busy   = r_busy;
    assign wr_stb = r_wr_stb;
    assign wr_adr = r_wr_adr;
    assign wr_dat = r_wr_dat;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C controller with open-drain SDA.
module tb_i2c_target_regs;
    localparam int T    = 12;  // SCL half period in clk cycles
    localparam int Q    = 3;   // SDA change point after SCL fall
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic       busy;
    logic       wr_stb;
    logic [7:0] wr_adr;
    logic [7:0] wr_dat;

    int n_chk  = 0;
    int n_pass = 0;

    int         wr_cnt = 0;
    logic [7:0] wr_adr_log [0:63];
    logic [7:0] wr_dat_log [0:63];

    assign sda_bus = m_sda & ~sda_oe;

    i2c_target_regs #(
        .I2C_ADR  (7'h11),
        .MEM_DEPTH(16),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .scl_i (m_scl),
        .sda_i (sda_bus),
        .sda_oe(sda_oe),
        .busy  (busy),
        .wr_stb(wr_stb),
        .wr_adr(wr_adr),
        .wr_dat(wr_dat)
    );

    always #5 clk = ~clk;

    // Log every write strobe
    always @(negedge clk) begin
        if (wr_stb === 1'b1 && wr_cnt < 64) begin
            wr_adr_log[wr_cnt] = wr_adr;
            wr_dat_log[wr_cnt] = wr_dat;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(Q); m_sda = b; wait_clk(T - Q);
        m_scl = 1'b1; wait_clk(T); m_scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wait_clk(Q); m_sda = 1'b1; wait_clk(T - Q);
        m_scl = 1'b1; wait_clk(T / 2); b = sda_bus; wait_clk(T - T / 2); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            wait_clk(Q); m_sda = 1'b1; wait_clk(T - Q); m_scl = 1'b1; wait_clk(T);
        end
        m_sda = 1'b0; wait_clk(T); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); m_sda = 1'b0; wait_clk(T - Q);
        m_scl = 1'b1; wait_clk(T); m_sda = 1'b1; wait_clk(T);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_bit(x);
        ack = ~x;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            get_bit(x);
            d[i] = x;
        end
        send_bit(nack);
    endtask

    task automatic test_reset();
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        wait_clk(3); rst = 1'b0; wait_clk(3);
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (wr_stb !== 1'b0) $display("FAIL reset_wr_stb: got %b want 0", wr_stb); else n_pass++;
        n_chk++; if (wr_adr !== 8'h00) $display("FAIL reset_wr_adr: got %h want 00", wr_adr); else n_pass++;
        n_chk++; if (wr_dat !== 8'h00) $display("FAIL reset_wr_dat: got %h want 00", wr_dat); else n_pass++;
    endtask

    // Address ACK lands exactly HOLD+3 clk after the raw SCL fall; also seeds mem[4]=3C
    task automatic test_hold_timing();
        logic ack;
        int   base;
        logic [7:0] a;
        base = wr_cnt;
        a = 8'h22;
        i2c_start();
        n_chk++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else n_pass++;
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        wait_clk(HOLD + 2);
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL hold_early: got %b want 0", sda_oe); else n_pass++;
        wait_clk(1);
        n_chk++; if (sda_oe !== 1'b1) $display("FAIL hold_exact: got %b want 1", sda_oe); else n_pass++;
        wait_clk(T - HOLD - 3); m_scl = 1'b1; wait_clk(T); m_scl = 1'b0;
        send_byte(8'h04, ack);
        n_chk++; if (ack !== 1'b1) $display("FAIL hold_ptr_ack: got %b want 1", ack); else n_pass++;
        send_byte(8'h3C, ack);
        n_chk++; if (ack !== 1'b1) $display("FAIL hold_data_ack: got %b want 1", ack); else n_pass++;
        i2c_stop();
        n_chk++; if (wr_cnt - base !== 1) $display("FAIL hold_wr_count: got %0d want 1", wr_cnt - base); else n_pass++;
        n_chk++; if (wr_dat_log[base] !== 8'h3C) $display("FAIL hold_wr_dat: got %h want 3c", wr_dat_log[base]); else n_pass++;
    endtask

    task automatic test_write();
        logic ack;
        logic [3:0] acks;
        int   base;
        base = wr_cnt;
        i2c_start();
        send_byte(8'h22, ack); acks[3] = ack;
        send_byte(8'h02, ack); acks[2] = ack;
        send_byte(8'hA5, ack); acks[1] = ack;
        send_byte(8'h5A, ack); acks[0] = ack;
        n_chk++; if (busy !== 1'b1) $display("FAIL write_busy_before_stop: got %b want 1", busy); else n_pass++;
        i2c_stop();
        n_chk++; if (acks !== 4'b1111) $display("FAIL write_acks: got %b want 1111", acks); else n_pass++;
        n_chk++; if (wr_cnt - base !== 2) $display("FAIL write_count: got %0d want 2", wr_cnt - base); else n_pass++;
        n_chk++; if ({wr_adr_log[base], wr_dat_log[base]} !== 16'h02A5)
            $display("FAIL write_first: got %h want 02a5", {wr_adr_log[base], wr_dat_log[base]}); else n_pass++;
        n_chk++; if ({wr_adr_log[base+1], wr_dat_log[base+1]} !== 16'h035A)
            $display("FAIL write_second: got %h want 035a", {wr_adr_log[base+1], wr_dat_log[base+1]}); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_read_rstart();
        logic ack;
        logic [2:0] acks;
        logic [7:0] d0, d1, d2;
        i2c_start();
        send_byte(8'h22, ack); acks[2] = ack;
        send_byte(8'h02, ack); acks[1] = ack;
        i2c_start();
        send_byte(8'h23, ack); acks[0] = ack;
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        wait_clk(T / 2);
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL read_release_after_nack: got %b want 0", sda_oe); else n_pass++;
        i2c_stop();
        n_chk++; if (acks !== 3'b111) $display("FAIL read_acks: got %b want 111", acks); else n_pass++;
        n_chk++; if (d0 !== 8'hA5) $display("FAIL read_byte0: got %h want a5", d0); else n_pass++;
        n_chk++; if (d1 !== 8'h5A) $display("FAIL read_byte1: got %h want 5a", d1); else n_pass++;
        // Pointer must now be 4, which holds 3C
        i2c_start();
        send_byte(8'h23, ack);
        read_byte(1'b1, d2);
        i2c_stop();
        n_chk++; if (d2 !== 8'h3C) $display("FAIL read_ptr_is_4: got %h want 3c", d2); else n_pass++;
    endtask

    task automatic test_wrap();
        logic ack;
        logic [2:0] acks;
        logic [7:0] d0, d1;
        int   base;
        base = wr_cnt;
        i2c_start();
        send_byte(8'h22, ack); acks[2] = ack;
        send_byte(8'h0F, ack); acks[1] = ack;
        send_byte(8'h01, ack); acks[0] = ack;
        send_byte(8'h02, ack);
        i2c_stop();
        n_chk++; if ({acks, ack} !== 4'b1111) $display("FAIL wrap_acks: got %b want 1111", {acks, ack}); else n_pass++;
        n_chk++; if ({wr_adr_log[base], wr_dat_log[base]} !== 16'h0F01)
            $display("FAIL wrap_first: got %h want 0f01", {wr_adr_log[base], wr_dat_log[base]}); else n_pass++;
        n_chk++; if ({wr_adr_log[base+1], wr_dat_log[base+1]} !== 16'h0002)
            $display("FAIL wrap_second: got %h want 0002", {wr_adr_log[base+1], wr_dat_log[base+1]}); else n_pass++;
        i2c_start();
        send_byte(8'h22, ack);
        send_byte(8'h0F, ack);
        i2c_start();
        send_byte(8'h23, ack);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        n_chk++; if ({d0, d1} !== 16'h0102) $display("FAIL wrap_read: got %h want 0102", {d0, d1}); else n_pass++;
    endtask

    task automatic test_nack();
        logic ack;
        int   base;
        base = wr_cnt;
        i2c_start();
        send_byte(8'h24, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL nack_wrong_addr: got %b want 0", ack); else n_pass++;
        send_byte(8'h99, ack);
        i2c_stop();
        i2c_start();
        send_byte(8'h22, ack);
        send_byte(8'h10, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL nack_ptr_range: got %b want 0", ack); else n_pass++;
        send_byte(8'h77, ack);
        n_chk++; if (ack !== 1'b0) $display("FAIL nack_ignore_data: got %b want 0", ack); else n_pass++;
        i2c_stop();
        n_chk++; if (wr_cnt - base !== 0) $display("FAIL nack_no_write: got %0d want 0", wr_cnt - base); else n_pass++;
        i2c_start();
        send_byte(8'h00, ack);
        i2c_stop();
        n_chk++; if (ack !== 1'b0) $display("FAIL nack_general_call: got %b want 0", ack); else n_pass++;
        i2c_start();
        send_byte(8'h22, ack);
        n_chk++; if (ack !== 1'b1) $display("FAIL nack_recover_addr: got %b want 1", ack); else n_pass++;
        send_byte(8'h06, ack);
        i2c_stop();
        n_chk++; if (ack !== 1'b1) $display("FAIL nack_recover_ptr: got %b want 1", ack); else n_pass++;
    endtask

    task automatic test_stop_mid();
        logic ack;
        logic [7:0] d;
        int   base;
        base = wr_cnt;
        i2c_start();
        send_byte(8'h22, ack);
        send_byte(8'h03, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        wait_clk(Q); m_sda = 1'b0; wait_clk(T - Q);
        m_scl = 1'b1; wait_clk(T); m_sda = 1'b1;
        wait_clk(2);
        n_chk++; if (busy !== 1'b1) $display("FAIL stop_busy_early: got %b want 1", busy); else n_pass++;
        wait_clk(1);
        n_chk++; if (busy !== 1'b0) $display("FAIL stop_busy_at_3: got %b want 0", busy); else n_pass++;
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL stop_sda_oe: got %b want 0", sda_oe); else n_pass++;
        wait_clk(T);
        n_chk++; if (wr_cnt - base !== 0) $display("FAIL stop_no_write: got %0d want 0", wr_cnt - base); else n_pass++;
        i2c_start();
        send_byte(8'h23, ack);
        read_byte(1'b1, d);
        i2c_stop();
        n_chk++; if (ack !== 1'b1) $display("FAIL stop_next_ack: got %b want 1", ack); else n_pass++;
        n_chk++; if (d !== 8'h5A) $display("FAIL stop_mem3_kept: got %h want 5a", d); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic b;
        logic [7:0] d;
        i2c_start();
        send_byte(8'h22, ack);
        send_byte(8'h02, ack);
        i2c_start();
        send_byte(8'h23, ack);
        get_bit(b);
        n_chk++; if (b !== 1'b1) $display("FAIL rstmid_bit7: got %b want 1", b); else n_pass++;
        wait_clk(6);
        n_chk++; if (sda_oe !== 1'b1) $display("FAIL rstmid_driving: got %b want 1", sda_oe); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (sda_oe !== 1'b0) $display("FAIL rstmid_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (wr_dat !== 8'h00) $display("FAIL rstmid_wr_dat: got %h want 00", wr_dat); else n_pass++;
        wait_clk(2); rst = 1'b0;
        m_sda = 1'b1; wait_clk(T); m_scl = 1'b1; wait_clk(T);
        i2c_start();
        send_byte(8'h22, ack);
        n_chk++; if (ack !== 1'b1) $display("FAIL rstmid_next_ack: got %b want 1", ack); else n_pass++;
        send_byte(8'h02, ack);
        i2c_start();
        send_byte(8'h23, ack);
        read_byte(1'b1, d);
        i2c_stop();
        n_chk++; if (d !== 8'h00) $display("FAIL rstmid_mem_cleared: got %h want 00", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_hold_timing();
        test_write();
        test_read_rstart();
        test_wrap();
        test_nack();
        test_stop_mid();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
